tick_pwm_gen: RTL and testbench

//  Downstream consumer of the periodic single-cycle tick from the pulse generator.

---
 rtl/tick_pwm_gen_pkg.sv | 13 +
 rtl/pwm_shadow_regs.sv | 83 ++++++++
 rtl/tick_pwm_gen.sv | 122 ++++++++++++
 tb/tb_tick_pwm_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_pwm_gen_pkg.sv
// Shared definitions for the tick-driven PWM generator: FSM encoding and default settings.
package tick_pwm_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pwm_state_e;

    localparam int DEF_CNT_W        = 8;
    localparam int DEF_PERIOD_TICKS = 10;
    localparam int DEF_DUTY_TICKS   = 5;

endpackage : tick_pwm_gen_pkg

// File: rtl/pwm_shadow_regs.sv
// Shadow/active period and duty registers. Software writes land in the shadow
// copy at any time; the active copy only takes the shadow value when the top
// requests a transfer (frame start or frame boundary).
module pwm_shadow_regs
    import tick_pwm_gen_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_TICKS,
    parameter int DEF_DUTY   = DEF_DUTY_TICKS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [CNT_W-1:0] req_period,
    input  logic [CNT_W-1:0] req_duty,
    input  logic             xfer,
    output logic [CNT_W-1:0] period_act,
    output logic [CNT_W-1:0] next_duty_act
);

    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEF_P_C  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_D_C  = CNT_W'(DEF_DUTY);

    // A zero-length frame is meaningless; treat a requested 0 as 1 tick.
    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] r;
        if (p == {CNT_W{1'b0}}) begin
            r = ONE_C;
        end else begin
            r = p;
        end
        return r;
    endfunction

    logic [CNT_W-1:0] shadow_period_r;
    logic [CNT_W-1:0] shadow_duty_r;
    logic [CNT_W-1:0] active_period_r;
    logic [CNT_W-1:0] active_duty_r;
    logic [CNT_W-1:0] next_duty_s;

    // Shadow capture on load strobe, independent of FSM state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow_period_r <= DEF_P_C;
            shadow_duty_r   <= DEF_D_C;
        end else if (load) begin
            shadow_period_r <= clamp_period(req_period);
            shadow_duty_r   <= req_duty;
        end else begin
            shadow_period_r <= shadow_period_r;
            shadow_duty_r   <= shadow_duty_r;
        end
    end

    // Active copy takes the pre-load shadow value on a transfer edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            active_period_r <= DEF_P_C;
            active_duty_r   <= DEF_D_C;
        end else if (xfer) begin
            active_period_r <= shadow_period_r;
            active_duty_r   <= shadow_duty_r;
        end else begin
            active_period_r <= active_period_r;
            active_duty_r   <= active_duty_r;
        end
    end

    // Look-ahead of the duty value that will be active after this edge.
    always_comb begin
        next_duty_s = active_duty_r;
        if (xfer) begin
            next_duty_s = shadow_duty_r;
        end else begin
            next_duty_s = active_duty_r;
        end
    end

    assign period_act    = active_period_r;
    assign next_duty_act = next_duty_s;

endmodule : pwm_shadow_regs

// File: rtl/tick_pwm_gen.sv
// Tick-counting PWM generator. Counts incoming ticks into frames of the active
// period, drives pwm high for the first duty ticks of each frame, and strobes
// frame_done_o on the edge after the closing tick. Disabling is graceful: the
// current frame always runs to completion.
module tick_pwm_gen
    import tick_pwm_gen_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_TICKS,
    parameter int DEF_DUTY   = DEF_DUTY_TICKS
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic             pwm_o,
    output logic             frame_done_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    pwm_state_e       state_r;
    pwm_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] next_cnt_s;
    logic             xfer_s;
    logic             frame_close_s;
    logic [CNT_W-1:0] period_act_s;
    logic [CNT_W-1:0] next_duty_act_s;
    logic             pwm_r;
    logic             frame_done_r;
    logic             busy_r;

    pwm_shadow_regs #(
        .CNT_W      (CNT_W),
        .DEF_PERIOD (DEF_PERIOD),
        .DEF_DUTY   (DEF_DUTY)
    ) u_shadow (
        .clk           (clk),
        .rstn          (rstn),
        .load          (load_i),
        .req_period    (period_i),
        .req_duty      (duty_i),
        .xfer          (xfer_s),
        .period_act    (period_act_s),
        .next_duty_act (next_duty_act_s)
    );

    // Next-state, next-count and frame-boundary decode.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        xfer_s        = 1'b0;
        frame_close_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                next_cnt_s = {CNT_W{1'b0}};
                if (en_i) begin
                    next_state_s = ST_RUN;
                    xfer_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_i) begin
                    if (cnt_r == (period_act_s - ONE_C)) begin
                        next_cnt_s    = {CNT_W{1'b0}};
                        frame_close_s = 1'b1;
                        xfer_s        = 1'b1;
                        if (en_i) begin
                            next_state_s = ST_RUN;
                        end else begin
                            next_state_s = ST_IDLE;
                        end
                    end else begin
                        next_cnt_s = cnt_r + ONE_C;
                    end
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                next_cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and frame counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Output flops computed from the post-edge state so they line up with cnt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_r        <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pwm_r        <= (next_state_s == ST_RUN) && (next_cnt_s < next_duty_act_s);
            frame_done_r <= frame_close_s;
            busy_r       <= (next_state_s == ST_RUN);
        end
    end

    assign pwm_o        = pwm_r;
    assign frame_done_o = frame_done_r;
    assign busy_o       = busy_r;

endmodule : tick_pwm_gen

// File: tb/tb_tick_pwm_gen.sv
// Self-checking bench for tick_pwm_gen: directed scenarios with hand-computed
// totals, then randomized traffic, all compared cycle by cycle to a frame model.
module tb_tick_pwm_gen;

    logic       clk;
    logic       rstn;
    logic       tick_i;
    logic       en_i;
    logic       load_i;
    logic [7:0] period_i;
    logic [7:0] duty_i;
    logic       pwm_o;
    logic       frame_done_o;
    logic       busy_o;

    int total;
    int bad;
    int hi_cnt;
    int done_cnt;
    int busy_cnt;

    // frame model: ticks elapsed in the current frame plus settings
    bit m_run;
    int m_pos;
    int m_sp, m_sd, m_ap, m_ad;
    bit e_pwm, e_busy, e_done;

    tick_pwm_gen dut (
        .clk          (clk),
        .rstn         (rstn),
        .tick_i       (tick_i),
        .en_i         (en_i),
        .load_i       (load_i),
        .period_i     (period_i),
        .duty_i       (duty_i),
        .pwm_o        (pwm_o),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_pos = 0;
        m_sp = 10; m_sd = 5; m_ap = 10; m_ad = 5;
        e_pwm = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    // One clock of the frame rules, using the inputs currently driven.
    task automatic model_step();
        int nsp, nsd;
        nsp = m_sp; nsd = m_sd;
        if (load_i) begin
            nsp = (period_i == 8'd0) ? 1 : int'(period_i);
            nsd = int'(duty_i);
        end
        e_done = 1'b0;
        if (!m_run) begin
            if (en_i) begin
                m_run = 1'b1; m_pos = 0; m_ap = m_sp; m_ad = m_sd;
            end
        end else if (tick_i) begin
            m_pos = m_pos + 1;
            if (m_pos == m_ap) begin
                m_pos = 0; e_done = 1'b1;
                m_ap = m_sp; m_ad = m_sd;
                m_run = en_i;
            end
        end
        if (!m_run) m_pos = 0;
        m_sp = nsp; m_sd = nsd;
        e_pwm  = m_run && (m_pos < m_ad);
        e_busy = m_run;
    endtask

    // Drive one cycle of inputs at the falling edge, then compare after the next rising edge.
    task automatic step(input logic en, input logic tk, input logic ld,
                        input logic [7:0] per, input logic [7:0] du);
        en_i = en; tick_i = tk; load_i = ld; period_i = per; duty_i = du;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("pwm", int'(pwm_o), int'(e_pwm));
        chk("busy", int'(busy_o), int'(e_busy));
        chk("frame_done", int'(frame_done_o), int'(e_done));
        hi_cnt   = hi_cnt + int'(pwm_o);
        done_cnt = done_cnt + int'(frame_done_o);
        busy_cnt = busy_cnt + int'(busy_o);
    endtask

    task automatic run_ticks(input int n, input logic en);
        for (int i = 0; i < n; i++) begin
            step(en, 1'b1, 1'b0, 8'd0, 8'd0);
            step(en, 1'b0, 1'b0, 8'd0, 8'd0);
        end
    endtask

    task automatic clr();
        hi_cnt = 0; done_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        total = 0; bad = 0;
        clr();
        rstn = 1'b0; tick_i = 1'b0; en_i = 1'b0; load_i = 1'b0;
        period_i = 8'd0; duty_i = 8'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_done", int'(frame_done_o), 0);
        rstn = 1'b1;

        // 1: defaults, tick every 4 clocks
        clr();
        for (int t = 0; t < 40; t++) step(1'b1, (t % 4 == 0) && (t != 0), 1'b0, 8'd0, 8'd0);
        chk("t1_high_cycles", hi_cnt, 20);
        chk("t1_no_early_done", done_cnt, 0);
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("t1_done_at_tick10", int'(frame_done_o), 1);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("t1_done_one_cycle", int'(frame_done_o), 0);

        // 2: mid-frame load 4/1 leaves current frame alone
        run_ticks(3, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd4, 8'd1);
        clr();
        run_ticks(7, 1'b1);
        chk("t2_old_frame_done", done_cnt, 1);
        chk("t2_old_frame_high", hi_cnt, 4);
        clr();
        run_ticks(8, 1'b1);
        chk("t2_new_frame_done", done_cnt, 2);
        chk("t2_new_frame_high", hi_cnt, 4);

        // 3: duty above period is stuck high, duty 0 stuck low
        step(1'b1, 1'b0, 1'b1, 8'd8, 8'd12);
        run_ticks(4, 1'b1);
        clr();
        run_ticks(8, 1'b1);
        chk("t3_stuck_high", hi_cnt, 16);
        step(1'b1, 1'b0, 1'b1, 8'd8, 8'd0);
        run_ticks(8, 1'b1);
        clr();
        run_ticks(8, 1'b1);
        chk("t3_stuck_low", hi_cnt, 0);
        chk("t3_busy_held", busy_cnt, 16);

        // 4: graceful stop after en drop at tick 3
        step(1'b1, 1'b0, 1'b1, 8'd10, 8'd5);
        run_ticks(8, 1'b1);
        run_ticks(3, 1'b1);
        clr();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
            step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        end
        chk("t4_still_busy", int'(busy_o), 1);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("t4_final_done", int'(frame_done_o), 1);
        chk("t4_idle_busy", int'(busy_o), 0);
        chk("t4_idle_pwm", int'(pwm_o), 0);
        run_ticks(3, 1'b0);
        chk("t4_stays_idle", int'(busy_o), 0);

        // 5: period 0 acts as 1-tick frames
        step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        clr();
        run_ticks(5, 1'b1);
        chk("t5_done_every_tick", done_cnt, 5);

        // 6: async reset mid-run, shadow returns to 10/5
        step(1'b1, 1'b0, 1'b1, 8'd3, 8'd2);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_pwm", int'(pwm_o), 0);
        chk("t6_async_busy", int'(busy_o), 0);
        chk("t6_async_done", int'(frame_done_o), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        run_ticks(3, 1'b0);
        chk("t6_idle_after_reset", int'(busy_o), 0);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        clr();
        run_ticks(10, 1'b1);
        chk("t6_default_period", done_cnt, 1);
        chk("t6_default_duty", hi_cnt, 10);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 19) == 0),
                 8'($urandom_range(0, 12)),
                 8'($urandom_range(0, 14)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_tick_pwm_gen
